seq_alu: RTL and testbench

//   Multi-cycle ALU that produces the 33-bit Calc word (bit 32 = carry/extra) consumed by the Status stage.

---
 rtl/seq_alu.sv | 147 ++++++++++++++
 tb/tb_seq_alu.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle 32-bit ALU with a Start/Busy/Done handshake.
// Single-cycle add/sub/logic ops, bit-serial shifts and a 32-step shift-add multiply.
module seq_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  opcode,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  output logic [32:0] calc,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] work_q, work_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        carry_q, carry_d;
  logic [32:0] calc_q, calc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [32:0] sum_w;
  logic [32:0] result_w;

  // Multiply keeps {high, low} in work_q; the low half starts as the multiplier
  // and is consumed LSB-first as the partial product shifts right into it.
  assign sum_w = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, a_q} : 33'd0);

  always_comb begin
    result_w = 33'd0;
    case (op_q)
      OP_ADD:  result_w = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  result_w = {1'b0, a_q} + {1'b0, ~b_q} + 33'd1;
      OP_AND:  result_w = {1'b0, a_q & b_q};
      OP_OR:   result_w = {1'b0, a_q | b_q};
      OP_XOR:  result_w = {1'b0, a_q ^ b_q};
      OP_SLL,
      OP_SRL:  result_w = {carry_q, work_q[31:0]};
      default: result_w = {|work_q[63:32], work_q[31:0]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    calc_d  = calc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      EXEC: begin
        if (cnt_q == 6'd0) begin
          calc_d  = result_w;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          case (op_q)
            OP_SLL: begin
              carry_d = work_q[31];
              work_d  = {32'd0, work_q[30:0], 1'b0};
            end
            OP_SRL: begin
              carry_d = work_q[0];
              work_d  = {32'd0, 1'b0, work_q[31:1]};
            end
            default: work_d = {sum_w, work_q[31:1]};
          endcase
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start) begin
          op_d    = opcode;
          a_d     = data_a;
          b_d     = data_b;
          carry_d = 1'b0;
          busy_d  = 1'b1;
          state_d = EXEC;
          work_d  = (opcode == OP_MUL) ? {32'd0, data_b} : {32'd0, data_a};
          if (opcode == OP_MUL)
            cnt_d = 6'd32;
          else if (opcode == OP_SLL || opcode == OP_SRL)
            cnt_d = {1'b0, data_b[4:0]};
          else
            cnt_d = 6'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      work_q  <= 64'd0;
      cnt_q   <= 6'd0;
      carry_q <= 1'b0;
      calc_q  <= 33'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      calc_q  <= calc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign calc = calc_q;
  assign op_a = a_q;
  assign op_b = b_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu: hand-computed results, latencies,
// handshake corner cases and asynchronous reset abort.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  opcode = 3'd0;
  logic [31:0] data_a = 32'd0;
  logic [31:0] data_b = 32'd0;
  logic [32:0] calc;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, SLL = 3'd5, SRL = 3'd6, MUL = 3'd7;

  always #5 clk = ~clk;

  seq_alu dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .opcode (opcode),
    .data_a (data_a),
    .data_b (data_b),
    .calc   (calc),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done)
  );

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Drive a request, let the accept edge pass, then scramble the inputs so
  // any late sampling of operands would show up in the result.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    opcode = op;
    data_a = a;
    data_b = b;
    tick(1);
    start  = 1'b0;
    opcode = 3'($urandom);
    data_a = $urandom;
    data_b = $urandom;
    $display("issue op=%0d a=%h b=%h", op, a, b);
  endtask

  task automatic chk_done(input string tag, input logic [32:0] exp);
    chk({tag, " done"}, {32'd0, done}, 33'd1);
    chk({tag, " busy"}, {32'd0, busy}, 33'd0);
    chk({tag, " calc"}, calc, exp);
    $display("%s: calc=%h done=%0b busy=%0b", tag, calc, done, busy);
  endtask

  task automatic chk_running(input string tag);
    chk({tag, " busy"}, {32'd0, busy}, 33'd1);
    chk({tag, " done"}, {32'd0, done}, 33'd0);
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst calc", calc, 33'd0);
    chk("rst op_a", {1'b0, op_a}, 33'd0);
    chk("rst op_b", {1'b0, op_b}, 33'd0);
    chk("rst busy", {32'd0, busy}, 33'd0);
    chk("rst done", {32'd0, done}, 33'd0);
    rst = 1'b0;
    tick(1);

    // ADD with carry out
    issue(ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    chk_running("add e0");
    tick(1);
    chk_done("add", 33'h1_0000_0000);
    chk("add op_a", {1'b0, op_a}, 33'h0_FFFF_FFFF);
    chk("add op_b", {1'b0, op_b}, 33'h0_0000_0001);
    tick(1);
    chk("add pulse", {32'd0, done}, 33'd0);

    // SUB with and without borrow, back-to-back from the Done cycle
    issue(SUB, 32'd5, 32'd7);
    tick(1);
    chk_done("sub 5-7", 33'h0_FFFF_FFFE);
    issue(SUB, 32'd7, 32'd5);
    chk_running("sub b2b e0");
    tick(1);
    chk_done("sub 7-5", 33'h1_0000_0002);

    // Logic ops, chained back-to-back
    issue(AND_, 32'hF0F0_F0F0, 32'hFF00_FF00);
    tick(1);
    chk_done("and", 33'h0_F000_F000);
    issue(OR_, 32'hF0F0_F0F0, 32'hFF00_FF00);
    tick(1);
    chk_done("or", 33'h0_FFF0_FFF0);
    issue(XOR_, 32'hF0F0_F0F0, 32'hFF00_FF00);
    tick(1);
    chk_done("xor", 33'h0_0FF0_0FF0);
    tick(1);

    // Shifts: k=0, k=1, k=31
    issue(SRL, 32'h8000_0001, 32'd0);
    tick(1);
    chk_done("srl k0", 33'h0_8000_0001);
    tick(1);
    issue(SLL, 32'h8000_0001, 32'd1);
    chk_running("sll1 e0");
    tick(1);
    chk_running("sll1 e1");
    chk("sll1 calc hold", calc, 33'h0_8000_0001);
    tick(1);
    chk_done("sll k1", 33'h1_0000_0002);
    tick(1);
    issue(SLL, 32'h0000_0003, 32'd31);
    tick(31);
    chk_running("sll31 e31");
    tick(1);
    chk_done("sll k31", 33'h1_8000_0000);
    issue(SRL, 32'h8000_0000, 32'h0000_007F);
    tick(32);
    chk_done("srl k31", 33'h0_0000_0001);
    tick(1);

    // MUL with nonzero high half
    issue(MUL, 32'hFFFF_FFFF, 32'd2);
    tick(32);
    chk_running("mul e32");
    tick(1);
    chk_done("mul big", 33'h1_FFFF_FFFE);
    tick(1);

    // MUL with a Start during EXEC that must be ignored
    issue(MUL, 32'h0000_1234, 32'h0000_0010);
    tick(4);
    start = 1'b1; opcode = ADD; data_a = 32'd1; data_b = 32'd1;
    tick(1);
    start = 1'b0;
    chk_running("mul ignore e5");
    chk("mul ignore op_a", {1'b0, op_a}, 33'h0_0000_1234);
    tick(27);
    chk_running("mul ignore e32");
    tick(1);
    chk_done("mul small", 33'h0_0001_2340);

    // Start in the Done cycle is accepted and completes on schedule
    issue(ADD, 32'd100, 32'd23);
    chk_running("b2b e0");
    tick(1);
    chk_done("b2b add", 33'h0_0000_007B);
    tick(1);

    // Asynchronous reset in the middle of a multiply
    issue(MUL, 32'h1234_5678, 32'h9ABC_DEF0);
    tick(10);
    #2 rst = 1'b1;
    #1;
    chk("arst calc", calc, 33'd0);
    chk("arst op_a", {1'b0, op_a}, 33'd0);
    chk("arst op_b", {1'b0, op_b}, 33'd0);
    chk("arst busy", {32'd0, busy}, 33'd0);
    chk("arst done", {32'd0, done}, 33'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(25);
    chk("arst no done", {32'd0, done}, 33'd0);
    chk("arst no busy", {32'd0, busy}, 33'd0);
    issue(ADD, 32'd2, 32'd3);
    tick(1);
    chk_done("post rst add", 33'h0_0000_0005);
    tick(1);
    chk("post rst pulse", {32'd0, done}, 33'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
